// File: rtl/avr_bus_map.sv
// avr_bus_map: memory-map fabric between the AVR core data port and up to
// REGIONS memory-mapped slaves.
//   - Decodes each CPU access against per-region base/mask pairs. On overlap
//     the lowest-index region wins.
//   - Holds the one-hot slave select for the whole access and inserts
//     WAITS_i wait states.
//   - Pulses the slave write strobe for exactly one cycle per write.
//   - Returns registered read data together with a one-cycle ready pulse.
//   - Logs unmapped accesses in a saturating counter plus the last bad address.
//
// Ports:
//   clock_i, reset_i         clock (rising edge), synchronous active-high reset
//   cpu_address_i            access address
//   cpu_wdata_i              write data
//   cpu_we_i, cpu_re_i       write / read request (write wins when both are set)
//   cpu_rdata_o              read data, valid while cpu_ready_o=1
//   cpu_ready_o              one-cycle access-complete pulse
//   slv_addr_o, slv_wdata_o  latched address / write data
//   slv_sel_o                one-hot region select, held for the whole access
//   slv_we_o                 one-hot write strobe, one cycle per write
//   slv_rdata_i              packed slave read data, region i at [i*DW +: DW]
//   err_count_o, err_addr_o  saturating unmapped-access count / last bad address
module avr_bus_map #(
  parameter int                      REGIONS = 4,
  parameter int                      AW      = 16,
  parameter int                      DW      = 8,
  parameter logic [REGIONS*AW-1:0]   BASE    = {REGIONS*AW{1'b0}},
  parameter logic [REGIONS*AW-1:0]   MASK    = {REGIONS*AW{1'b0}},
  parameter logic [REGIONS*4-1:0]    WAITS   = {REGIONS*4{1'b0}},
  parameter logic [DW-1:0]           DEFAULT = {DW{1'b1}}
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic [AW-1:0]         cpu_address_i,
  input  logic [DW-1:0]         cpu_wdata_i,
  input  logic                  cpu_we_i,
  input  logic                  cpu_re_i,
  output logic [DW-1:0]         cpu_rdata_o,
  output logic                  cpu_ready_o,
  output logic [AW-1:0]         slv_addr_o,
  output logic [DW-1:0]         slv_wdata_o,
  output logic [REGIONS-1:0]    slv_sel_o,
  output logic [REGIONS-1:0]    slv_we_o,
  input  logic [REGIONS*DW-1:0] slv_rdata_i,
  output logic [7:0]            err_count_o,
  output logic [AW-1:0]         err_addr_o
);

  localparam int IW = (REGIONS > 1) ? $clog2(REGIONS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 write_q, write_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [REGIONS-1:0]   sel_q, sel_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [DW-1:0]        wdata_q, wdata_d;
  logic [DW-1:0]        rdata_q, rdata_d;
  logic [7:0]           errc_q, errc_d;
  logic [AW-1:0]        erra_q, erra_d;

  // Address decode.
  // The loop scans from the top index down, so the lowest hitting region
  // is the last one written and wins on overlap.
  logic          hit;
  logic [IW-1:0] hit_idx;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = REGIONS - 1; i >= 0; i--) begin
      if ((cpu_address_i & MASK[i*AW +: AW]) == (BASE[i*AW +: AW] & MASK[i*AW +: AW])) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    idx_d       = idx_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    errc_d      = errc_q;
    erra_d      = erra_q;
    slv_we_o    = '0;
    cpu_ready_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cpu_we_i || cpu_re_i) begin
          addr_d  = cpu_address_i;
          wdata_d = cpu_wdata_i;
          write_d = cpu_we_i;  // a simultaneous read is dropped
          if (hit) begin
            idx_d   = hit_idx;
            sel_d   = REGIONS'(1) << hit_idx;
            cnt_d   = WAITS[int'(hit_idx)*4 +: 4];
            state_d = S_WAIT;
          end else begin
            sel_d   = '0;
            rdata_d = DEFAULT;
            if (errc_q != 8'hFF) errc_d = errc_q + 8'd1;
            erra_d  = cpu_address_i;
            state_d = S_DONE;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Reset gating keeps an aborted access from strobing the slave.
          if (write_q) slv_we_o = sel_q & {REGIONS{~reset_i}};
          else         rdata_d  = slv_rdata_i[int'(idx_q)*DW +: DW];
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        cpu_ready_o = ~reset_i;
        sel_d       = '0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      idx_q   <= '0;
      sel_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= DEFAULT;
      errc_q  <= '0;
      erra_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      errc_q  <= errc_d;
      erra_q  <= erra_d;
    end
  end

  assign cpu_rdata_o = rdata_q;
  assign slv_addr_o  = addr_q;
  assign slv_wdata_o = wdata_q;
  assign slv_sel_o   = sel_q;
  assign err_count_o = errc_q;
  assign err_addr_o  = erra_q;

endmodule

// File: tb/tb_avr_bus_map.sv
// Directed bench for avr_bus_map.
// Region map:
//   0: BASE 8000, MASK F000, 0 waits
//   1: BASE C000, MASK F000, 3 waits
//   2: BASE 8000, MASK F800, 2 waits (overlaps region 0)
//   3: BASE A000, MASK F000, 5 waits
// Each slave returns a distinct data byte: 5A / A1 / B2 / C3.
module tb_avr_bus_map;
  localparam int REGIONS = 4;
  localparam int AW = 16;
  localparam int DW = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [AW-1:0]     cpu_address;
  logic [DW-1:0]     cpu_wdata;
  logic              cpu_we, cpu_re;
  logic [DW-1:0]     cpu_rdata;
  logic              cpu_ready;
  logic [AW-1:0]     slv_addr;
  logic [DW-1:0]     slv_wdata;
  logic [REGIONS-1:0] slv_sel, slv_we;
  logic [REGIONS*DW-1:0] slv_rdata;
  logic [7:0]        err_count;
  logic [AW-1:0]     err_addr;

  always #5 clk = ~clk;

  avr_bus_map #(
    .REGIONS(4), .AW(16), .DW(8),
    .BASE ({16'hA000, 16'h8000, 16'hC000, 16'h8000}),
    .MASK ({16'hF000, 16'hF800, 16'hF000, 16'hF000}),
    .WAITS({4'd5, 4'd2, 4'd3, 4'd0}),
    .DEFAULT(8'hFF)
  ) dut (
    .clock_i(clk), .reset_i(rst),
    .cpu_address_i(cpu_address), .cpu_wdata_i(cpu_wdata),
    .cpu_we_i(cpu_we), .cpu_re_i(cpu_re),
    .cpu_rdata_o(cpu_rdata), .cpu_ready_o(cpu_ready),
    .slv_addr_o(slv_addr), .slv_wdata_o(slv_wdata),
    .slv_sel_o(slv_sel), .slv_we_o(slv_we), .slv_rdata_i(slv_rdata),
    .err_count_o(err_count), .err_addr_o(err_addr)
  );

  int checks = 0;
  int errors = 0;

  // Results of the most recent access.
  int         lat, we_cnt, we_k;
  logic [7:0] rd;
  logic [3:0] we_v, sel0;
  logic       post_ready;
  logic [3:0] post_sel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one request, drop the inputs right after acceptance, then follow
  // the access until cpu_ready (bounded) and one cycle beyond it.
  // Latency is counted in cycles after the accepting edge.
  task automatic access(input logic [15:0] a, input logic [7:0] d, input logic we, input logic re);
    cpu_address = a; cpu_wdata = d; cpu_we = we; cpu_re = re;
    @(posedge clk); #1;
    cpu_we = 1'b0; cpu_re = 1'b0; cpu_address = '0; cpu_wdata = '0;
    sel0 = slv_sel; lat = 0; we_cnt = 0; we_k = -1; we_v = '0; rd = '0;
    forever begin
      if (slv_we != '0) begin we_cnt++; we_k = lat; we_v = slv_we; end
      if (cpu_ready) begin rd = cpu_rdata; break; end
      if (lat >= 40) begin lat = -1; break; end
      @(posedge clk); #1;
      lat++;
    end
    @(posedge clk); #1;
    if (slv_we != '0) we_cnt++;
    post_ready = cpu_ready;
    post_sel   = slv_sel;
  endtask

  initial begin
    int bad;
    int quiet;
    slv_rdata = {8'hC3, 8'hB2, 8'hA1, 8'h5A};
    rst = 1'b1; cpu_address = '0; cpu_wdata = '0; cpu_we = 1'b0; cpu_re = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata", cpu_rdata, 8'hFF);
    chk("rst_ready", cpu_ready, 0);
    chk("rst_sel", slv_sel, 0);
    chk("rst_we", slv_we, 0);
    chk("rst_addr", slv_addr, 0);
    chk("rst_wdata", slv_wdata, 0);
    chk("rst_errc", err_count, 0);
    chk("rst_erra", err_addr, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Read from region 0, zero waits.
    access(16'h8123, 8'h00, 1'b0, 1'b1);
    chk("rd0_sel", sel0, 4'b0001);
    chk("rd0_addr", slv_addr, 16'h8123);
    chk("rd0_lat", lat, 1);
    chk("rd0_data", rd, 8'h5A);
    chk("rd0_we", we_cnt, 0);
    chk("rd0_ready_pulse", post_ready, 0);
    chk("rd0_sel_clr", post_sel, 0);
    chk("rd0_errc", err_count, 0);

    // Write to region 1, three waits.
    access(16'hC010, 8'h3C, 1'b1, 1'b0);
    chk("wr1_sel", sel0, 4'b0010);
    chk("wr1_we_cnt", we_cnt, 1);
    chk("wr1_we_k", we_k, 3);
    chk("wr1_we_v", we_v, 4'b0010);
    chk("wr1_lat", lat, 4);
    chk("wr1_rdata_hold", rd, 8'h5A);
    chk("wr1_wdata", slv_wdata, 8'h3C);
    chk("wr1_addr", slv_addr, 16'hC010);

    // 8004 hits both region 0 and region 2; region 0 must win.
    access(16'h8004, 8'h00, 1'b0, 1'b1);
    chk("ovl_sel", sel0, 4'b0001);
    chk("ovl_lat", lat, 1);
    chk("ovl_data", rd, 8'h5A);

    // Region 3 read with five waits.
    access(16'hA010, 8'h00, 1'b0, 1'b1);
    chk("rd3_sel", sel0, 4'b1000);
    chk("rd3_lat", lat, 6);
    chk("rd3_data", rd, 8'hC3);

    // Write and read together: treated as a write only.
    access(16'h8001, 8'h77, 1'b1, 1'b1);
    chk("both_sel", sel0, 4'b0001);
    chk("both_we_cnt", we_cnt, 1);
    chk("both_we_k", we_k, 0);
    chk("both_we_v", we_v, 4'b0001);
    chk("both_lat", lat, 1);
    chk("both_rdata_hold", rd, 8'hC3);
    chk("both_wdata", slv_wdata, 8'h77);

    // Unmapped reads, enough to saturate the error counter.
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      access(16'h1234, 8'h00, 1'b0, 1'b1);
      if (lat != 0 || rd !== 8'hFF || sel0 !== 4'b0000 || we_cnt != 0) bad++;
      if (i == 0) begin
        chk("miss_errc1", err_count, 1);
        chk("miss_erra", err_addr, 16'h1234);
        chk("miss_addr", slv_addr, 16'h1234);
      end
      if (i == 253) chk("miss_errc_fe", err_count, 8'hFE);
      if (i == 254) chk("miss_errc_ff", err_count, 8'hFF);
    end
    chk("miss_loop_bad", bad, 0);
    chk("miss_errc_sat", err_count, 8'hFF);
    chk("miss_erra_end", err_addr, 16'h1234);

    // Reset in the middle of a five-wait write to region 3.
    cpu_address = 16'hA000; cpu_wdata = 8'h55; cpu_we = 1'b1; cpu_re = 1'b0;
    @(posedge clk); #1;
    cpu_we = 1'b0; cpu_address = '0; cpu_wdata = '0;
    chk("abort_sel", slv_sel, 4'b1000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("abort_we_in_rst", slv_we, 0);
    chk("abort_ready_in_rst", cpu_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_sel_rst", slv_sel, 0);
    chk("abort_we_rst", slv_we, 0);
    chk("abort_ready_rst", cpu_ready, 0);
    chk("abort_rdata_rst", cpu_rdata, 8'hFF);
    chk("abort_addr_rst", slv_addr, 0);
    chk("abort_wdata_rst", slv_wdata, 0);
    chk("abort_errc_rst", err_count, 0);
    chk("abort_erra_rst", err_addr, 0);
    quiet = 0;
    for (int i = 0; i < 8; i++) begin
      if (slv_we != '0 || cpu_ready) quiet++;
      @(posedge clk); #1;
    end
    chk("abort_no_activity", quiet, 0);

    // The next request after the abort completes normally.
    access(16'h8123, 8'h00, 1'b0, 1'b1);
    chk("post_sel", sel0, 4'b0001);
    chk("post_lat", lat, 1);
    chk("post_data", rd, 8'h5A);
    chk("post_errc", err_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
